// File: rtl/mul_pipe_hs_if.sv
// Handshake bundle for mul_pipe_hs: operand request side and product response side.
interface mul_pipe_hs_if #(
  parameter int SIZE1 = 4,
  parameter int SIZE2 = 4,
  parameter int TAG_W = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [SIZE1-1:0]       a;
  logic [SIZE2-1:0]       b;
  logic                   tc;
  logic [TAG_W-1:0]       tag_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [SIZE1+SIZE2-1:0] y;
  logic [TAG_W-1:0]       tag_out;
  logic                   busy;

  modport master (
    output in_valid, a, b, tc, tag_in, out_ready,
    input  in_ready, out_valid, y, tag_out, busy
  );
  modport slave (
    input  in_valid, a, b, tc, tag_in, out_ready,
    output in_ready, out_valid, y, tag_out, busy
  );
endinterface

// File: rtl/mul_pipe_hs.sv
// Pipelined signed/unsigned multiplier with valid/ready handshake and global stall.
// Each stage adds one C-bit slice of ext_b's partial product into a running accumulator.
module mul_pipe_hs #(
  parameter int SIZE1  = 4,
  parameter int SIZE2  = 4,
  parameter int STAGES = 3,
  parameter int TAG_W  = 4
) (
  input logic         clk,
  input logic         rst,
  mul_pipe_hs_if.slave bus
);
  localparam int W  = SIZE1 + SIZE2;
  localparam int C  = (W + STAGES - 1) / STAGES;
  localparam int BW = STAGES * C;

  logic                          stall;
  logic                          accept;
  logic [W-1:0]                  ext_a;
  logic [W-1:0]                  ext_b;
  logic [STAGES-1:0]             vld_pipe;
  logic [STAGES-1:0]             vld_in;
  logic [STAGES-1:0][W-1:0]      a_in;
  logic [STAGES-1:0][W-1:0]      acc_in;
  logic [STAGES-1:0][BW-1:0]     b_in;
  logic [STAGES-1:0][TAG_W-1:0]  tag_s;

  assign stall        = bus.out_valid && !bus.out_ready;
  assign bus.in_ready = !stall;
  assign accept       = bus.in_valid && !stall;
  assign bus.busy     = |vld_pipe;

  // Mode is folded into the extension here, so it travels implicitly with the operands.
  assign ext_a = bus.tc ? {{SIZE2{bus.a[SIZE1-1]}}, bus.a} : {{SIZE2{1'b0}}, bus.a};
  assign ext_b = bus.tc ? {{SIZE1{bus.b[SIZE2-1]}}, bus.b} : {{SIZE1{1'b0}}, bus.b};

  assign vld_in[0] = accept;
  assign a_in[0]   = ext_a;
  assign b_in[0]   = BW'(ext_b);
  assign acc_in[0] = '0;
  assign tag_s[0]  = bus.tag_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             v_q;
    logic [W-1:0]     acc_q;
    logic [W-1:0]     pp;
    logic [TAG_W-1:0] tag_q;
    logic [BW-1:0]    b_use;

    // b_in[k] carries only the not-yet-consumed slices, so in the last stage the
    // whole vector equals its own slice.
    assign b_use = (k == STAGES - 1) ? b_in[k] : BW'(b_in[k][C-1:0]);
    assign pp    = W'(a_in[k] * b_use);

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        acc_q <= '0;
        tag_q <= '0;
      end else if (!stall) begin
        v_q   <= vld_in[k];
        acc_q <= acc_in[k] + (pp << (k * C));
        tag_q <= tag_s[k];
      end
    end

    assign vld_pipe[k] = v_q;

    if (k < STAGES - 1) begin : g_fwd
      logic [W-1:0]  a_q;
      logic [BW-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= a_in[k];
          b_q <= b_in[k] >> C;
        end
      end

      assign vld_in[k+1] = v_q;
      assign a_in[k+1]   = a_q;
      assign b_in[k+1]   = b_q;
      assign acc_in[k+1] = acc_q;
      assign tag_s[k+1]  = tag_q;
    end else begin : g_out
      assign bus.out_valid = v_q;
      assign bus.y         = acc_q;
      assign bus.tag_out   = tag_q;
    end
  end
endmodule

// File: tb/tb_mul_pipe_hs.sv
// Scoreboard bench for mul_pipe_hs: three configurations (8x8/3 stages, 4x4/1 stage,
// 3x2/7 stages so that STAGES exceeds the product width).
module tb_mul_pipe_hs;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_pipe_hs_if #(.SIZE1(8), .SIZE2(8), .TAG_W(4)) ifa ();
  mul_pipe_hs_if #(.SIZE1(4), .SIZE2(4), .TAG_W(4)) ifb ();
  mul_pipe_hs_if #(.SIZE1(3), .SIZE2(2), .TAG_W(4)) ifc ();

  mul_pipe_hs #(.SIZE1(8), .SIZE2(8), .STAGES(3), .TAG_W(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  mul_pipe_hs #(.SIZE1(4), .SIZE2(4), .STAGES(1), .TAG_W(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  mul_pipe_hs #(.SIZE1(3), .SIZE2(2), .STAGES(7), .TAG_W(4)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  typedef struct {
    logic [63:0] y;
    int          tag;
    int          due;
    int          sbase;
  } exp_t;

  exp_t sbq[3][$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   samp    = 0;
  int   stalls[3];
  int   pushed[3];
  bit   seen[3];
  int   STG[3] = '{3, 1, 7};
  int   SA[3]  = '{8, 4, 3};
  int   SB[3]  = '{8, 4, 2};

  logic       drst;
  logic       dv[3];
  logic [7:0] da[3];
  logic [7:0] db[3];
  logic       dtc[3];
  logic [3:0] dtag[3];
  logic       dordy[3];

  function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @samp %0d: got 0x%0h, required 0x%0h", nm, samp, got, exp);
    end
  endfunction

  // Exact product of the operands read at their own width, reduced mod 2^(SA+SB).
  function automatic logic [63:0] ref_mul(int id, logic [7:0] a, logic [7:0] b, logic tc);
    longint ea, eb, p;
    ea = longint'(a) & ((longint'(1) << SA[id]) - 1);
    eb = longint'(b) & ((longint'(1) << SB[id]) - 1);
    if (tc && ea[SA[id]-1]) ea = ea - (longint'(1) << SA[id]);
    if (tc && eb[SB[id]-1]) eb = eb - (longint'(1) << SB[id]);
    p = ea * eb;
    return 64'(p) & ((64'd1 << (SA[id] + SB[id])) - 64'd1);
  endfunction

  function automatic logic rdy(int id);
    case (id)
      0:       return ifa.in_ready;
      1:       return ifb.in_ready;
      default: return ifc.in_ready;
    endcase
  endfunction

  // One cycle: apply staged inputs at the falling edge, then log what the next rising edge accepts.
  task automatic step();
    @(negedge clk);
    rst = drst;
    ifa.in_valid = dv[0]; ifa.a = da[0];      ifa.b = db[0];      ifa.tc = dtc[0];
    ifa.tag_in = dtag[0]; ifa.out_ready = dordy[0];
    ifb.in_valid = dv[1]; ifb.a = da[1][3:0]; ifb.b = db[1][3:0]; ifb.tc = dtc[1];
    ifb.tag_in = dtag[1]; ifb.out_ready = dordy[1];
    ifc.in_valid = dv[2]; ifc.a = da[2][2:0]; ifc.b = db[2][1:0]; ifc.tc = dtc[2];
    ifc.tag_in = dtag[2]; ifc.out_ready = dordy[2];
    samp++;
    #1;
    for (int id = 0; id < 3; id++) begin
      pushed[id] = 0;
      if (rst) begin
        sbq[id].delete();
        seen[id] = 1'b0;
      end else if (dv[id] && rdy(id)) begin
        exp_t e;
        e.y     = ref_mul(id, da[id], db[id], dtc[id]);
        e.tag   = int'(dtag[id]);
        e.due   = samp + STG[id];
        e.sbase = stalls[id];
        sbq[id].push_back(e);
        pushed[id] = 1;
      end
    end
  endtask

  task automatic op(int id, logic [7:0] a, logic [7:0] b, logic tc, logic [3:0] tag);
    dv[id] = 1'b1; da[id] = a; db[id] = b; dtc[id] = tc; dtag[id] = tag;
  endtask

  task automatic idle();
    for (int id = 0; id < 3; id++) dv[id] = 1'b0;
  endtask

  task automatic mon(int id);
    logic        ov, ordy, ir, bz;
    logic [63:0] y;
    int          tg, live;
    exp_t        h;
    case (id)
      0: begin ov = ifa.out_valid; ordy = ifa.out_ready; ir = ifa.in_ready; bz = ifa.busy;
               y = 64'(ifa.y); tg = int'(ifa.tag_out); end
      1: begin ov = ifb.out_valid; ordy = ifb.out_ready; ir = ifb.in_ready; bz = ifb.busy;
               y = 64'(ifb.y); tg = int'(ifb.tag_out); end
      default: begin ov = ifc.out_valid; ordy = ifc.out_ready; ir = ifc.in_ready; bz = ifc.busy;
               y = 64'(ifc.y); tg = int'(ifc.tag_out); end
    endcase
    if (rst) return;
    live = sbq[id].size() - pushed[id];
    chk($sformatf("in_ready%0d", id), 64'(ir), 64'(!(ov && !ordy)));
    chk($sformatf("busy%0d", id), 64'(bz), 64'(live > 0));
    if (ov) begin
      if (live == 0) chk($sformatf("unexpected_out%0d", id), 64'(ov), 64'd0);
      else begin
        h = sbq[id][0];
        chk($sformatf("y%0d", id), y, h.y);
        chk($sformatf("tag%0d", id), 64'(tg), 64'(h.tag));
        if (!seen[id]) chk($sformatf("latency%0d", id), 64'(samp), 64'(h.due + stalls[id] - h.sbase));
        seen[id] = 1'b1;
        if (ordy) begin
          void'(sbq[id].pop_front());
          seen[id] = 1'b0;
        end
      end
    end else if (live > 0) begin
      h = sbq[id][0];
      if (samp >= h.due + stalls[id] - h.sbase) chk($sformatf("late%0d", id), 64'(ov), 64'd1);
    end
    if (ov && !ordy) stalls[id]++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      for (int id = 0; id < 3; id++) mon(id);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  logic [7:0] tp_a[4] = '{8'h03, 8'h00, 8'hFF, 8'h07};
  logic [7:0] tp_b[4] = '{8'h04, 8'h09, 8'h01, 8'h07};
  logic       tp_t[4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b1;
    drst = 1'b1;
    for (int id = 0; id < 3; id++) begin
      dv[id] = 1'b0; da[id] = '0; db[id] = '0; dtc[id] = 1'b0; dtag[id] = '0; dordy[id] = 1'b1;
      stalls[id] = 0; pushed[id] = 0; seen[id] = 1'b0;
    end
    repeat (3) step();
    drst = 1'b0;
    step();
    #2;
    chk("rst_out_valid", 64'(ifa.out_valid), 64'd0);
    chk("rst_busy", 64'(ifa.busy), 64'd0);
    chk("rst_y", 64'(ifa.y), 64'd0);
    chk("rst_tag", 64'(ifa.tag_out), 64'd0);
    chk("rst_in_ready", 64'(ifa.in_ready), 64'd1);
    chk("rst_y_b", 64'(ifb.y), 64'd0);
    chk("rst_ov_c", 64'(ifc.out_valid), 64'd0);

    // Unsigned corner and the single-stage signed/unsigned pair.
    op(0, 8'hFF, 8'hFF, 1'b0, 4'd5);
    op(1, 8'h0F, 8'h0F, 1'b1, 4'd1);
    step();
    dv[0] = 1'b0;
    op(1, 8'h0F, 8'h0F, 1'b0, 4'd2);
    step();
    idle();
    repeat (6) step();

    // Same operands, signed then unsigned, back to back.
    op(0, 8'h80, 8'h7F, 1'b1, 4'd6);
    step();
    op(0, 8'h80, 8'h7F, 1'b0, 4'd7);
    step();
    idle();
    repeat (5) step();

    for (int i = 0; i < 4; i++) begin
      op(0, tp_a[i], tp_b[i], tp_t[i], 4'(i));
      step();
    end
    idle();
    repeat (6) step();

    // Fill the pipe against a stalled consumer, keep offering operands, then release.
    dordy[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      op(0, 8'($urandom), 8'($urandom), 1'($urandom), 4'(8 + i));
      step();
    end
    idle();
    dordy[0] = 1'b1;
    repeat (8) step();

    // Reset with two operations in flight.
    op(0, 8'h12, 8'h34, 1'b0, 4'd9);
    step();
    op(0, 8'h56, 8'h78, 1'b1, 4'd10);
    step();
    idle();
    drst = 1'b1;
    step();
    drst = 1'b0;
    step();
    #2;
    chk("midrst_out_valid", 64'(ifa.out_valid), 64'd0);
    chk("midrst_busy", 64'(ifa.busy), 64'd0);
    repeat (10) step();

    for (int n = 0; n < 400; n++) begin
      for (int id = 0; id < 3; id++) begin
        dv[id]    = ($urandom_range(0, 9) < 7);
        da[id]    = 8'($urandom);
        db[id]    = 8'($urandom);
        dtc[id]   = 1'($urandom);
        dtag[id]  = 4'($urandom);
        dordy[id] = ($urandom_range(0, 9) < 7);
      end
      step();
    end

    idle();
    for (int id = 0; id < 3; id++) dordy[id] = 1'b1;
    for (int i = 0; i < 60 && (sbq[0].size() + sbq[1].size() + sbq[2].size()) > 0; i++) step();
    step();
    chk("drain_left", 64'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
